// File: rtl/vend_pkg.sv
// Shared types for the vending dispenser: FSM states, change codes and
// the queued sale entry layout.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ITEM_DRV,
        ST_ITEM_WAIT,
        ST_COIN_DRV,
        ST_COIN_WAIT,
        ST_GAP,
        ST_FINISH
    } state_e;

    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_HALF = 2'b01;
    localparam logic [1:0] CHG_ONE  = 2'b10;
    localparam logic [1:0] CHG_BAD  = 2'b11;

    typedef struct packed {
        logic       thing;
        logic [1:0] coins;
    } entry_t;

    // Invalid code pays nothing; its item part (if any) is still honoured.
    function automatic logic [1:0] decode_coins(input logic [1:0] code);
        logic [1:0] n;
        case (code)
            CHG_HALF: n = 2'd1;
            CHG_ONE:  n = 2'd2;
            default:  n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; pop on empty and push on full
// (without a same-cycle pop) are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/vend_dispenser.sv
// Queues per-sale item/change results and drives the item and coin
// ejectors, confirming every action through the drop sensors.
//
// state      | meaning
// IDLE       | waiting; pops the next queued entry
// ITEM_DRV   | item ejector driven for PULSE_CYC cycles
// ITEM_WAIT  | waiting for item sensor (or timeout)
// COIN_DRV   | coin ejector driven for PULSE_CYC cycles
// COIN_WAIT  | waiting for coin sensor (or timeout)
// GAP        | settle time before the next coin
// FINISH     | entry complete, done pulse is high
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned PULSE_CYC   = 50000,
    parameter int unsigned TIMEOUT_CYC = 5000000,
    parameter int unsigned GAP_CYC     = 25000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pi_thing,
    input  logic [1:0] pi_money,
    input  logic       item_sensor,
    input  logic       coin_sensor,
    output logic       item_eject,
    output logic       coin_eject,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    output logic       fault,
    output logic       bad_code
);

    localparam int unsigned MAX_PT  = (PULSE_CYC > TIMEOUT_CYC) ? PULSE_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_MAX = (MAX_PT > GAP_CYC) ? MAX_PT : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PULSE_N      = CNT_W'(PULSE_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       cur_coins_q;
    logic             conf_q;
    logic             item_eject_q, coin_eject_q, done_q;
    logic             overflow_q, fault_q, bad_code_q;

    entry_t ev_entry, head;
    logic   ev_push, ev_bad, pop, fifo_full, fifo_empty;

    assign ev_bad         = (pi_money == CHG_BAD);
    assign ev_entry.thing = pi_thing;
    assign ev_entry.coins = decode_coins(pi_money);
    assign ev_push        = pi_thing || (ev_entry.coins != 2'd0);
    assign pop            = (state_q == ST_IDLE) && !fifo_empty;

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ev_push),
        .pop_i   (pop),
        .din_i   (ev_entry),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cur_coins_q  <= 2'd0;
            conf_q       <= 1'b0;
            item_eject_q <= 1'b0;
            coin_eject_q <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            fault_q      <= 1'b0;
            bad_code_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ev_bad) bad_code_q <= 1'b1;
            if (ev_push && fifo_full && !pop) overflow_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_coins_q <= head.coins;
                        cnt_q       <= '0;
                        conf_q      <= 1'b0;
                        state_q     <= head.thing ? ST_ITEM_DRV : ST_COIN_DRV;
                    end
                end
                ST_ITEM_DRV: begin
                    if (item_sensor) conf_q <= 1'b1;
                    if (cnt_q == PULSE_N) begin
                        item_eject_q <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= ST_ITEM_WAIT;
                    end else begin
                        item_eject_q <= 1'b1;
                        cnt_q        <= cnt_q + CNT_ONE;
                    end
                end
                ST_ITEM_WAIT: begin
                    if (conf_q) begin
                        conf_q <= 1'b0;
                        cnt_q  <= '0;
                        if (cur_coins_q != 2'd0) begin
                            state_q <= ST_GAP;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        fault_q     <= 1'b1;
                        cur_coins_q <= 2'd0;
                        done_q      <= 1'b1;
                        state_q     <= ST_FINISH;
                    end else begin
                        if (item_sensor) conf_q <= 1'b1;
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_COIN_DRV: begin
                    if (coin_sensor) conf_q <= 1'b1;
                    if (cnt_q == PULSE_N) begin
                        coin_eject_q <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= ST_COIN_WAIT;
                    end else begin
                        coin_eject_q <= 1'b1;
                        cnt_q        <= cnt_q + CNT_ONE;
                    end
                end
                ST_COIN_WAIT: begin
                    if (conf_q) begin
                        conf_q      <= 1'b0;
                        cnt_q       <= '0;
                        cur_coins_q <= cur_coins_q - 2'd1;
                        if (cur_coins_q > 2'd1) begin
                            state_q <= ST_GAP;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        fault_q     <= 1'b1;
                        cur_coins_q <= 2'd0;
                        done_q      <= 1'b1;
                        state_q     <= ST_FINISH;
                    end else begin
                        if (coin_sensor) conf_q <= 1'b1;
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_COIN_DRV;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_FINISH: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign item_eject = item_eject_q;
    assign coin_eject = coin_eject_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign fault      = fault_q;
    assign bad_code   = bad_code_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser with an auto-responding sensor model
// and a negedge monitor that accumulates pulse statistics.
module tb_vend_dispenser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pi_thing = 1'b0;
    logic [1:0] pi_money = 2'b00;
    logic       man_item = 1'b0, man_coin = 1'b0;
    logic       resp_item = 1'b0, resp_coin = 1'b0;
    logic       resp_item_en = 1'b1, resp_coin_en = 1'b1;
    logic       item_sensor, coin_sensor;
    logic       item_eject, coin_eject, busy, done, overflow, fault, bad_code;

    assign item_sensor = man_item | resp_item;
    assign coin_sensor = man_coin | resp_coin;

    always #5 clk = ~clk;

    vend_dispenser #(
        .PULSE_CYC   (4),
        .TIMEOUT_CYC (20),
        .GAP_CYC     (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pi_thing    (pi_thing),
        .pi_money    (pi_money),
        .item_sensor (item_sensor),
        .coin_sensor (coin_sensor),
        .item_eject  (item_eject),
        .coin_eject  (coin_eject),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .fault       (fault),
        .bad_code    (bad_code)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic t, input logic [1:0] m);
        pi_thing = t;
        pi_money = m;
        tick();
        pi_thing = 1'b0;
        pi_money = 2'b00;
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n = 0;
        while (busy && n < maxc) begin
            tick();
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic wait_coin(input logic lvl, input int maxc, input string tag);
        int n = 0;
        while (coin_eject !== lvl && n < maxc) begin
            tick();
            n++;
        end
        check(tag, coin_eject, lvl);
    endtask

    // Sensor model: pulse the matching sensor 3 cycles after its drive falls.
    initial begin
        int   idly = 0, cdly = 0;
        logic pi = 1'b0, pc = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            resp_item = 1'b0;
            resp_coin = 1'b0;
            if (idly > 0) begin
                idly--;
                if (idly == 0 && resp_item_en) resp_item = 1'b1;
            end
            if (cdly > 0) begin
                cdly--;
                if (cdly == 0 && resp_coin_en) resp_coin = 1'b1;
            end
            if (pi && !item_eject) idly = 3;
            if (pc && !coin_eject) cdly = 3;
            pi = item_eject;
            pc = coin_eject;
        end
    end

    int cyc = 0, done_tot = 0, item_hi_tot = 0, coin_hi_tot = 0, coin_rise_tot = 0;
    int bad_item_run = 0, bad_coin_run = 0, short_gap = 0;
    int coin_fall_cyc = 0, fault_rise_cyc = 0;

    initial begin
        int   irun = 0, crun = 0, clow = 0;
        logic pi = 1'b0, pc = 1'b0, pf = 1'b0, seen = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done) done_tot++;
            if (item_eject) begin
                item_hi_tot++;
                irun++;
            end else if (pi) begin
                if (irun != 4) bad_item_run++;
                irun = 0;
            end
            if (coin_eject) begin
                coin_hi_tot++;
                crun++;
                if (!pc) begin
                    coin_rise_tot++;
                    if (seen && clow < 2) short_gap++;
                end
            end else begin
                if (pc) begin
                    coin_fall_cyc = cyc;
                    if (crun != 4) bad_coin_run++;
                    crun = 0;
                    clow = 0;
                    seen = 1'b1;
                end
                clow++;
            end
            if (fault && !pf) fault_rise_cyc = cyc;
            pf = fault;
            pi = item_eject;
            pc = coin_eject;
        end
    end

    int b_done, b_item, b_coin, b_rise, b_badi, b_badc, b_gap;

    task automatic snap();
        b_done = done_tot;
        b_item = item_hi_tot;
        b_coin = coin_hi_tot;
        b_rise = coin_rise_tot;
        b_badi = bad_item_run;
        b_badc = bad_coin_run;
        b_gap  = short_gap;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_item_eject", item_eject, 1'b0);
        check("rst_coin_eject", coin_eject, 1'b0);
        check("rst_busy",       busy,       1'b0);
        check("rst_done",       done,       1'b0);
        check("rst_overflow",   overflow,   1'b0);
        check("rst_fault",      fault,      1'b0);
        check("rst_bad_code",   bad_code,   1'b0);
        rst = 1'b0;
        tick();

        // Item plus two half coins, all confirmed
        snap();
        send(1'b1, 2'b10);
        check("t1_busy", busy, 1'b1);
        check("t1_item_e0", item_eject, 1'b0);
        tick();
        check("t1_item_e1", item_eject, 1'b0);
        tick();
        check("t1_item_rise", item_eject, 1'b1);
        wait_idle(300, "t1_idle");
        tick();
        check("t1_item_cycles", item_hi_tot - b_item, 4);
        check("t1_coin_cycles", coin_hi_tot - b_coin, 8);
        check("t1_coin_pulses", coin_rise_tot - b_rise, 2);
        check("t1_item_runlen", bad_item_run - b_badi, 0);
        check("t1_coin_runlen", bad_coin_run - b_badc, 0);
        check("t1_coin_gap", short_gap - b_gap, 0);
        check("t1_done", done_tot - b_done, 1);
        check("t1_fault", fault, 1'b0);

        // One coin, sensor silent: timeout
        resp_coin_en = 1'b0;
        snap();
        send(1'b0, 2'b01);
        wait_idle(300, "t2_idle");
        tick();
        check("t2_coin_cycles", coin_hi_tot - b_coin, 4);
        check("t2_fault", fault, 1'b1);
        check("t2_fault_lat", fault_rise_cyc - coin_fall_cyc, 20);
        check("t2_done", done_tot - b_done, 1);
        resp_coin_en = 1'b1;

        // Six back-to-back events: five accepted, sixth dropped
        snap();
        check("t3_ovf_before", overflow, 1'b0);
        for (int i = 0; i < 5; i++) send(1'b1, 2'b00);
        check("t3_ovf_fifth", overflow, 1'b0);
        send(1'b1, 2'b00);
        check("t3_ovf_sixth", overflow, 1'b1);
        wait_idle(1000, "t3_idle");
        tick();
        check("t3_done", done_tot - b_done, 5);
        check("t3_item_cycles", item_hi_tot - b_item, 20);
        check("t3_item_runlen", bad_item_run - b_badi, 0);

        // Invalid change code with an item
        check("t4_bad_before", bad_code, 1'b0);
        snap();
        send(1'b1, 2'b11);
        check("t4_bad_code", bad_code, 1'b1);
        wait_idle(300, "t4_idle");
        tick();
        check("t4_item_cycles", item_hi_tot - b_item, 4);
        check("t4_coin_cycles", coin_hi_tot - b_coin, 0);
        check("t4_done", done_tot - b_done, 1);

        // Reset in the middle of a coin pulse with another entry queued
        send(1'b0, 2'b01);
        send(1'b0, 2'b10);
        wait_coin(1'b1, 50, "t5_coin_start");
        tick();
        check("t5_coin_mid", coin_eject, 1'b1);
        rst = 1'b1;
        tick();
        check("t5_coin_eject", coin_eject, 1'b0);
        check("t5_busy",       busy,       1'b0);
        check("t5_done",       done,       1'b0);
        check("t5_overflow",   overflow,   1'b0);
        check("t5_fault",      fault,      1'b0);
        check("t5_bad_code",   bad_code,   1'b0);
        rst = 1'b0;
        repeat (6) tick();
        check("t5_busy_after", busy, 1'b0);
        check("t5_coin_after", coin_eject, 1'b0);

        // Stray sensor pulses are ignored
        snap();
        man_coin = 1'b1;
        tick();
        man_coin = 1'b0;
        tick();
        tick();
        check("t6_idle_busy", busy, 1'b0);
        check("t6_idle_done", done_tot - b_done, 0);
        resp_coin_en = 1'b0;
        snap();
        send(1'b0, 2'b01);
        wait_coin(1'b1, 50, "t6_coin_start");
        wait_coin(1'b0, 50, "t6_coin_end");
        tick();
        tick();
        man_item = 1'b1;
        tick();
        man_item = 1'b0;
        wait_idle(300, "t6_idle");
        tick();
        check("t6_fault", fault, 1'b1);
        check("t6_fault_lat", fault_rise_cyc - coin_fall_cyc, 20);
        check("t6_coin_cycles", coin_hi_tot - b_coin, 4);
        check("t6_done", done_tot - b_done, 1);
        resp_coin_en = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
Output-side executor for the coin-vending controller. It consumes the controller's per-sale result pulses: a 1-cycle item flag and a 2-bit change code. It queues them and drives the physical item ejector and 0.5-unit coin ejector, confirming each action through sensor feedback. It sits between the vending FSM outputs and the actuator pins, and reports completion, overflow and jam faults.

Parameters:
PULSE_CYC, 50000, actuator drive width in clk cycles (1 ms @ 50 MHz)
TIMEOUT_CYC, 5000000, max cycles to wait for sensor confirmation after drive ends
GAP_CYC, 25000, idle cycles between consecutive actuator actions
FIFO_DEPTH, 4, number of queued sale events (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
pi_thing  in  1  1-cycle pulse: an item is owed
pi_money  in  2  change code, sampled same cycle as pi_thing; 00 none, 01 one 0.5 coin, 10 two 0.5 coins, 11 invalid
item_sensor  in  1  1-cycle pulse: item passed drop sensor
coin_sensor  in  1  1-cycle pulse: coin passed coin sensor
item_eject  out  1  item actuator drive
coin_eject  out  1  coin actuator drive
busy  out  1  high whenever FSM not IDLE or FIFO non-empty
done  out  1  1-cycle pulse when an entry has finished, whether it succeeded or was aborted
overflow  out  1  sticky: an event was dropped because FIFO was full
fault  out  1  sticky: a sensor timeout occurred
bad_code  out  1  sticky: pi_money==11 was received

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0; FIFO empty; FSM IDLE; all counters 0. rst mid-action aborts immediately, and the actuators drop on that same edge.
- Enqueue: an event is pi_thing=1 or pi_money!=00. It is stored as {thing, coins}, where coins = 0/1/2 decoded from pi_money.
- Code 11 stores coins=0 and sets bad_code. If pi_thing is also 0, nothing is stored.
- FIFO full with no pop in the same cycle: event dropped, overflow set.
- FIFO full with a pop in the same cycle: push accepted.
- FSM states: IDLE, ITEM_DRV, ITEM_WAIT, COIN_DRV, COIN_WAIT, GAP, FINISH.
- IDLE: if FIFO non-empty, pop into cur_thing/cur_coins. Next state is ITEM_DRV if thing=1, else COIN_DRV.
- ITEM_DRV / COIN_DRV: the matching eject output is high for exactly PULSE_CYC cycles, registered. It rises on the cycle after the state is entered.
- ITEM_WAIT / COIN_WAIT: the timeout counter starts at 0 on entry.
- A sensor pulse seen during DRV or WAIT is latched as confirmation. WAIT exits on the cycle after it sees the latch.
- Confirmation on an item: the item counts as served.
- Confirmation on a coin: cur_coins decrements.
- Then, if work remains (cur_coins>0), go to GAP. Otherwise go to FINISH.
- GAP: hold GAP_CYC cycles, then COIN_DRV. Items are always served before coins.
- Timeout: the counter reaches TIMEOUT_CYC with no confirmation. Then set fault, discard the rest of the current entry, and go to FINISH. Later queued entries are still processed.
- FINISH: done=1 for one cycle, then IDLE. There is no back-to-back pop from FINISH; the next pop happens in IDLE.
- Sensor pulses in IDLE, GAP, or from the non-active sensor are ignored.
- Counters are sized to hold the largest parameter value; there is no wrap during normal operation.
- Sticky flags clear only on rst.

Decomposition:
- Package vend_pkg holds:
  - the state enum;
  - the change-code constants CHG_NONE/CHG_HALF/CHG_ONE/CHG_BAD;
  - the entry typedef {thing, coins[1:0]}.
- Sub-module sync_fifo (parameterised width and depth; push/pop/full/empty) is natural.
- The FSM, timers and sticky flags stay in vend_dispenser.

Test Plan:
Bench parameters for all cases: PULSE_CYC=4, TIMEOUT_CYC=20, GAP_CYC=2, FIFO_DEPTH=4.
- pi_thing=1, pi_money=10; sensors respond 3 cycles after each drive falls -> item_eject 4 cycles; then two coin_eject pulses of 4 cycles each, separated by at least 2 gap cycles; one done pulse; fault=0.
- pi_thing=0, pi_money=01, coin_sensor never pulses -> coin_eject 4 cycles; fault rises exactly 20 cycles after drive ends; done pulses; FSM returns to IDLE.
- Six events on consecutive cycles while busy -> first is popped, next four are queued, the sixth sets overflow; five done pulses total.
- pi_money=11 with pi_thing=1 -> bad_code=1; only the item is ejected.
- rst asserted mid coin_eject -> next edge: coin_eject=0, busy=0, FIFO empty, all flags 0.
- coin_sensor pulse during IDLE and item_sensor pulse during COIN_WAIT -> ignored; the timeout still fires.
